// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Enough BCD digits to hold any value of 4*num_digits bits (1233/4096 ~ log10(2)).
    function automatic int bcd_digits(input int num_digits);
        return ((4 * num_digits * 1233) >> 12) + 1;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_bcd_converter.sv
// Sequential double-dabble: one add-3/shift step per cycle, BIN_W cycles per conversion.
// bcd_out/overflow_out are the combinational result of the final step, valid while done=1.
module seven_seg_bcd_converter
    import seg7_pkg::*;
#(
    parameter int BIN_W      = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow_out
);

    localparam int BCD_DIGITS = bcd_digits(NUM_DIGITS);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CW         = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_sh;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_nxt;
    logic [CW-1:0]    step;

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
    end

    assign done         = busy && (step == CW'(BIN_W - 1));
    assign bcd_out      = bcd_nxt[4*NUM_DIGITS-1:0];
    assign overflow_out = |bcd_nxt[BCD_W-1:4*NUM_DIGITS];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy   <= 1'b0;
            step   <= '0;
            bin_sh <= '0;
            bcd_q  <= '0;
        end else if (busy) begin
            bcd_q  <= bcd_nxt;
            bin_sh <= bin_sh << 1;
            step   <= step + CW'(1);
            if (done)
                busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            step   <= '0;
            bin_sh <= bin_in;
            bcd_q  <= '0;
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver: hex/decimal load, digit scan,
// PWM brightness, leading-zero blanking and per-digit decimal points.
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int COUNT_TO   = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic                    mode_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz_in,
    input  logic [3:0]              bright_in,
    input  logic                    en_in,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    overflow_out
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(COUNT_TO);
    localparam int TW = $clog2(16 * COUNT_TO + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]                    state;
    logic [NUM_DIGITS-1:0][3:0]    disp_q;
    logic                          ovf_q;
    logic                          accept;
    logic                          load_dec;
    logic                          conv_busy;
    logic                          conv_done;
    logic [4*NUM_DIGITS-1:0]       conv_bcd;
    logic                          conv_ovf;

    logic [SW-1:0]                 slot_cnt;
    logic [IW-1:0]                 idx;
    logic                          slot_wrap;
    logic [TW-1:0]                 duty_prod;
    logic                          in_duty;
    logic [NUM_DIGITS-1:0]         blank;
    logic                          zero_above;
    logic                          lit;

    // ---------------- load path ----------------
    assign ready_out = (state == ST_IDLE) && !conv_busy;
    assign accept    = valid_in && ready_out;
    assign load_dec  = mode_e'(mode_in) == MODE_DEC;

    seven_seg_bcd_converter #(
        .BIN_W      (4 * NUM_DIGITS),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start        (accept && load_dec),
        .bin_in       (val_in),
        .busy         (conv_busy),
        .done         (conv_done),
        .bcd_out      (conv_bcd),
        .overflow_out (conv_ovf)
    );

    // Display and overflow only change together, so no partial result is ever shown.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state  <= ST_IDLE;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (load_dec) begin
                            state <= ST_CONV;
                        end else begin
                            disp_q <= val_in;
                            ovf_q  <= 1'b0;
                        end
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        disp_q <= conv_bcd;
                        ovf_q  <= conv_ovf;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign overflow_out = ovf_q;

    // ---------------- scan ----------------
    assign slot_wrap = (slot_cnt == SW'(COUNT_TO - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // Lit window is (bright+1)/16 of the slot, starting at slot_cnt 0.
    assign duty_prod = (TW'(bright_in) + TW'(1)) * TW'(COUNT_TO);
    assign in_duty   = TW'(slot_cnt) < (duty_prod >> 4);

    // Digit i blanks when it and everything above it is zero; overflow dashes are never blanked.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (disp_q[i] == 4'd0);
            blank[i]   = blank_lz_in && zero_above && !ovf_q;
        end
    end

    assign lit = en_in && in_duty && !blank[idx];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            an_out  <= '1;
            cat_out <= SEG_OFF;
            dp_out  <= 1'b1;
        end else if (lit) begin
            an_out  <= ~(NUM_DIGITS'(1) << idx);
            cat_out <= ovf_q ? SEG_DASH : glyph(disp_q[idx]);
            dp_out  <= ~dp_in[idx];
        end else begin
            an_out  <= '1;
            cat_out <= SEG_OFF;
            dp_out  <= 1'b1;
        end
    end

endmodule
